mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_pkg.sv | 40 ++++
 rtl/tx_fifo.sv | 63 ++++++
 rtl/mmio_uart_tx.sv | 195 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared register offsets, STATUS bit positions and FSM encoding
//
// Purpose: constants and small helpers shared by the UART transmitter and its bench.
// Ports: none (package).
package mmio_pkg;

   // Register offsets within the 16-byte window (DataAdr[3:0])
   localparam logic [3:0] OFF_TXDATA  = 4'h0;
   localparam logic [3:0] OFF_STATUS  = 4'h4;
   localparam logic [3:0] OFF_BAUDDIV = 4'h8;

   // STATUS bit positions
   localparam int STAT_BUSY  = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_EMPTY = 2;
   localparam int STAT_OVF   = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_state_t;

   // Serial line level presented while in a given state
   function automatic logic line_level(input uart_state_t st, input logic data_bit);
      case (st)
         S_IDLE:  return 1'b1;
         S_START: return 1'b0;
         S_DATA:  return data_bit;
         default: return 1'b1;
      endcase
   endfunction

   // A divider of 0 behaves as 1 so a bit always lasts at least one clock
   function automatic logic [15:0] bit_period(input logic [15:0] div);
      return (div == 16'd0) ? 16'd1 : div;
   endfunction

endpackage

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - transmit byte FIFO with occupancy count
//
// Purpose: DEPTH-entry FIFO holding bytes waiting to be serialised.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   push, din         - write strobe and data (ignored while full)
//   pop, dout         - read strobe (ignored while empty) and head data
//   full, empty       - occupancy flags
//   count             - number of stored entries
module tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !reset) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter with byte FIFO
//
// Purpose: three-register MMIO window (TXDATA, STATUS, BAUDDIV) feeding an
// 8N1 serialiser.
// Ports:
//   clk, reset_input      - clock, synchronous active-high reset
//   DataAdr, WriteData    - processor address and store data
//   MemWrite              - processor store strobe
//   RD                    - combinational read data for the addressed register
//   sel                   - combinational window hit for the top-level read mux
//   tx                    - registered serial line, idle high
module mmio_uart_tx
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
   parameter int          FIFO_DEPTH  = 4,
   parameter int          DEFAULT_DIV = 16
) (
   input  logic        clk,
   input  logic        reset_input,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   output logic [31:0] RD,
   output logic        sel,
   output logic        tx
);

   logic [3:0]  offset;
   logic        wr_txdata;
   logic        wr_status;
   logic        wr_baud;

   logic        overflow_q;
   logic [15:0] baud_q;

   logic        fifo_pop;
   logic        fifo_full;
   logic        fifo_empty;
   logic [7:0]  fifo_dout;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   uart_state_t state_q, state_n;
   logic [15:0] cnt_q, cnt_n;
   logic [15:0] period_q, period_n;
   logic [15:0] new_period;
   logic [2:0]  idx_q, idx_n;
   logic [7:0]  shift_q, shift_n;
   logic        tx_q;
   logic [31:0] status;
   logic        unused_bits;

   assign offset    = DataAdr[3:0];
   assign sel       = (DataAdr[31:4] == BASE_ADDR[31:4]);
   assign wr_txdata = MemWrite & sel & (offset == OFF_TXDATA);
   assign wr_status = MemWrite & sel & (offset == OFF_STATUS);
   assign wr_baud   = MemWrite & sel & (offset == OFF_BAUDDIV);

   assign unused_bits = ^{WriteData[31:16], fifo_count};

   tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .reset (reset_input),
      .push  (wr_txdata),
      .din   (WriteData[7:0]),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Overflow set takes priority over a clear on the same edge; full is the
   // pre-edge value, so a simultaneous pop does not rescue the byte.
   always_ff @(posedge clk) begin
      if (reset_input) begin
         overflow_q <= 1'b0;
         baud_q     <= 16'(DEFAULT_DIV);
      end else begin
         if (wr_txdata && fifo_full) begin
            overflow_q <= 1'b1;
         end else if (wr_status && WriteData[STAT_OVF]) begin
            overflow_q <= 1'b0;
         end
         if (wr_baud) begin
            baud_q <= WriteData[15:0];
         end
      end
   end

   always_comb begin
      status             = '0;
      status[STAT_BUSY]  = (state_q != S_IDLE);
      status[STAT_FULL]  = fifo_full;
      status[STAT_EMPTY] = fifo_empty;
      status[STAT_OVF]   = overflow_q;
   end

   always_comb begin
      RD = '0;
      if (sel) begin
         case (offset)
            OFF_STATUS:  RD = status;
            OFF_BAUDDIV: RD = {16'h0000, baud_q};
            default:     RD = '0;
         endcase
      end
   end

   assign new_period = bit_period(baud_q);

   always_ff @(posedge clk) begin
      if (reset_input) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         period_q <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
      end else begin
         state_q  <= state_n;
         cnt_q    <= cnt_n;
         period_q <= period_n;
         idx_q    <= idx_n;
         shift_q  <= shift_n;
         tx_q     <= line_level(state_q, shift_q[0]);
      end
   end

   assign tx = tx_q;

   // The divider is sampled only when a frame starts, so BAUDDIV writes
   // during a frame take effect on the following frame.
   always_comb begin
      logic start_frame;
      state_n     = state_q;
      cnt_n       = cnt_q;
      period_n    = period_q;
      idx_n       = idx_q;
      shift_n     = shift_q;
      fifo_pop    = 1'b0;
      start_frame = 1'b0;

      if (state_q != S_IDLE) begin
         cnt_n = (cnt_q == 16'd0) ? period_q - 16'd1 : cnt_q - 16'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) start_frame = 1'b1;
         end
         S_START: begin
            if (cnt_q == 16'd0) begin
               state_n = S_DATA;
               idx_n   = 3'd0;
            end
         end
         S_DATA: begin
            if (cnt_q == 16'd0) begin
               if (idx_q == 3'd7) begin
                  state_n = S_STOP;
               end else begin
                  idx_n   = idx_q + 3'd1;
                  shift_n = {1'b0, shift_q[7:1]};
               end
            end
         end
         S_STOP: begin
            if (cnt_q == 16'd0) begin
               if (!fifo_empty) begin
                  start_frame = 1'b1;
               end else begin
                  state_n = S_IDLE;
                  cnt_n   = 16'd0;
                  idx_n   = 3'd0;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase

      if (start_frame) begin
         fifo_pop = 1'b1;
         shift_n  = fifo_dout;
         state_n  = S_START;
         period_n = new_period;
         cnt_n    = new_period - 16'd1;
         idx_n    = 3'd0;
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx
//
// Purpose: directed register/serial scenarios with a frame scoreboard.
// Ports: none (top-level bench).
module tb_mmio_uart_tx;

   logic        clk = 1'b0;
   logic        reset_input;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic [31:0] RD;
   logic        sel;
   logic        tx;

   always #5 clk = ~clk;

   mmio_uart_tx #(
      .BASE_ADDR   (32'h0000_0100),
      .FIFO_DEPTH  (4),
      .DEFAULT_DIV (16)
   ) dut (
      .clk         (clk),
      .reset_input (reset_input),
      .DataAdr     (DataAdr),
      .WriteData   (WriteData),
      .MemWrite    (MemWrite),
      .RD          (RD),
      .sel         (sel),
      .tx          (tx)
   );

   typedef struct {
      logic [7:0] data;
      int         div;
      bit         contig;
   } frame_t;

   frame_t sb[$];
   int     tests = 0;
   int     fails = 0;
   bit     mon_active = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   // Caller sits just after a posedge; the next posedge is the write edge
   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      DataAdr   = addr;
      WriteData = data;
      MemWrite  = 1'b1;
      @(posedge clk);
      #1;
      MemWrite  = 1'b0;
      DataAdr   = 32'h0;
   endtask

   task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
      DataAdr = addr;
      #1;
      check(name, RD, exp);
      DataAdr = 32'h0;
   endtask

   task automatic expect_frame(input logic [7:0] data, input int div, input bit contig);
      frame_t f;
      f.data   = data;
      f.div    = div;
      f.contig = contig;
      sb.push_back(f);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 3000 && (sb.size() != 0 || mon_active); i++) @(posedge clk);
      #1;
      check(name, {31'b0, (sb.size() != 0 || mon_active)}, 32'h0);
   endtask

   // Frame monitor: checks every clock of each expected frame on the line
   frame_t m_f;
   int     m_n;
   logic   m_lvl;
   logic   m_act;
   initial begin
      forever begin
         while (sb.size() == 0) @(negedge clk);
         m_f = sb.pop_front();
         mon_active = 1'b1;
         @(negedge clk);
         if (m_f.contig) check($sformatf("gap before frame %02h", m_f.data), {31'b0, tx}, 32'h0);
         m_n = 0;
         while (tx !== 1'b0 && m_n < 3000) begin
            @(negedge clk);
            m_n++;
         end
         if (tx !== 1'b0) begin
            check($sformatf("start timeout frame %02h", m_f.data), {31'b0, tx}, 32'h0);
         end else begin
            for (int b = 0; b < 10; b++) begin
               m_lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : m_f.data[b-1];
               m_act = m_lvl;
               for (int k = 0; k < m_f.div; k++) begin
                  if (!(b == 0 && k == 0)) @(negedge clk);
                  if (tx !== m_lvl) m_act = tx;
               end
               check($sformatf("frame %02h bit %0d", m_f.data, b), {31'b0, m_act}, {31'b0, m_lvl});
            end
         end
         mon_active = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   bit quiet;

   initial begin
      reset_input = 1'b1;
      MemWrite    = 1'b0;
      DataAdr     = 32'h0;
      WriteData   = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      reset_input = 1'b0;

      // Reset state and decode
      check("reset tx", {31'b0, tx}, 32'h1);
      rd_check("reset status", 32'h104, 32'h4);
      rd_check("reset bauddiv", 32'h108, 32'h10);
      DataAdr = 32'h104;
      #1;
      check("sel in window", {31'b0, sel}, 32'h1);
      DataAdr = 32'h200;
      #1;
      check("sel outside window", {31'b0, sel}, 32'h0);
      @(posedge clk);
      #1;
      wr(32'h200, 32'h41);
      wr(32'h208, 32'h3);
      repeat (5) @(posedge clk);
      #1;
      check("outside write no frame", {31'b0, tx}, 32'h1);
      rd_check("outside write status", 32'h104, 32'h4);
      rd_check("outside write bauddiv", 32'h108, 32'h10);
      rd_check("read 0x10C", 32'h10C, 32'h0);
      rd_check("read txdata", 32'h100, 32'h0);

      // Single frame at DIV=4
      @(posedge clk);
      #1;
      wr(32'h108, 32'h4);
      rd_check("bauddiv 4", 32'h108, 32'h4);
      expect_frame(8'h55, 4, 1'b0);
      wr(32'h100, 32'h55);
      @(posedge clk);
      #1;
      check("tx high one edge after write", {31'b0, tx}, 32'h1);
      @(posedge clk);
      #1;
      check("tx falls second edge after write", {31'b0, tx}, 32'h0);
      repeat (38) @(posedge clk);
      #1;
      rd_check("busy at 40 clocks", 32'h104, 32'h5);
      @(posedge clk);
      #1;
      rd_check("idle at 41 clocks", 32'h104, 32'h4);
      drain("drain single");

      // Back-to-back frames
      expect_frame(8'hA5, 4, 1'b0);
      expect_frame(8'h3C, 4, 1'b1);
      wr(32'h100, 32'hA5);
      wr(32'h100, 32'h3C);
      repeat (79) @(posedge clk);
      #1;
      rd_check("b2b busy at 80", 32'h104, 32'h5);
      @(posedge clk);
      #1;
      rd_check("b2b idle at 81", 32'h104, 32'h4);
      drain("drain b2b");

      // Divider change mid-frame, then divider 0
      expect_frame(8'h96, 4, 1'b0);
      wr(32'h100, 32'h96);
      repeat (10) @(posedge clk);
      #1;
      wr(32'h108, 32'h0001_0002);
      rd_check("bauddiv truncated to 16 bits", 32'h108, 32'h2);
      expect_frame(8'h3C, 2, 1'b1);
      wr(32'h100, 32'h3C);
      drain("drain div change");
      wr(32'h108, 32'h0);
      rd_check("bauddiv 0", 32'h108, 32'h0);
      expect_frame(8'hF0, 1, 1'b0);
      wr(32'h100, 32'hF0);
      drain("drain div 0");
      wr(32'h108, 32'h4);

      // Overflow
      expect_frame(8'h01, 4, 1'b0);
      expect_frame(8'h02, 4, 1'b1);
      expect_frame(8'h03, 4, 1'b1);
      expect_frame(8'h04, 4, 1'b1);
      expect_frame(8'h05, 4, 1'b1);
      for (int i = 1; i <= 6; i++) wr(32'h100, i);
      rd_check("overflow status", 32'h104, 32'hB);
      wr(32'h104, 32'h8);
      rd_check("overflow cleared", 32'h104, 32'h3);
      drain("drain overflow");
      rd_check("status after overflow drain", 32'h104, 32'h4);

      // Reset mid-frame with a write on the reset edge
      wr(32'h100, 32'hAA);
      wr(32'h100, 32'hBB);
      wr(32'h100, 32'hCC);
      wr(32'h100, 32'hDD);
      repeat (12) @(posedge clk);
      #1;
      reset_input = 1'b1;
      DataAdr     = 32'h108;
      WriteData   = 32'h7;
      MemWrite    = 1'b1;
      @(posedge clk);
      #1;
      reset_input = 1'b0;
      MemWrite    = 1'b0;
      DataAdr     = 32'h0;
      check("tx after reset", {31'b0, tx}, 32'h1);
      rd_check("status after reset", 32'h104, 32'h4);
      rd_check("bauddiv after reset", 32'h108, 32'h10);
      quiet = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) quiet = 1'b0;
      end
      check("no frames after reset", {31'b0, quiet}, 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
